// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Purpose  : PS/2 set-2 byte parser (E0/F0 prefixes), Shift/Caps tracking,
//             ASCII mapping and a first-word-fall-through key-event FIFO.
//  Option   : define PS2_TYPEMATIC_SUPPRESS_EN to drop typematic repeat makes.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             code_valid,
   input  logic [7:0]       code_data,
   input  logic             ev_ready,
   input  logic             ovf_clr,
   output logic             ev_valid,
   output logic [7:0]       ev_ascii,
   output logic [7:0]       ev_scan,
   output logic             ev_release,
   output logic             ev_ext,
   output logic             shift_held,
   output logic             caps_on,
   output logic [CNT_W-1:0] key_cnt,
   output logic             overflow
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_EW = 18;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic           w_emit;
   logic           w_emit_ext;
   logic           w_emit_rel;
   logic           w_make;
   logic           w_suppress;
   logic           w_push_req;
   logic           w_push;
   logic           w_pop;
   logic           w_drop;
   logic           w_full;
   logic           w_empty;
   logic [7:0]     w_ascii;
   logic [c_EW-1:0] w_head;

   logic           r_shift_l;
   logic           r_shift_r;
   logic           r_caps_on;
   logic           r_caps_held;
   logic [c_AW:0]  r_wr_ptr;
   logic [c_AW:0]  r_rd_ptr;
   logic [c_EW-1:0] r_mem [FIFO_DEPTH];
   logic [CNT_W-1:0] r_key_cnt;
   logic           r_overflow;

   // Scancode to ASCII; letters honour the upper-case selector, digits do not.
   function automatic logic [7:0] f_ascii(input logic [7:0] scan, input logic upper);
      logic       is_letter;
      logic [4:0] idx;
      logic [7:0] res;
      is_letter = 1'b1;
      idx       = 5'd0;
      res       = 8'd0;
      case (scan)
         8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
         8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
         8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
         8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
         8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
         8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
         8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
         8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
         8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
         default: is_letter = 1'b0;
      endcase
      if (is_letter) begin
         res = (upper ? 8'd65 : 8'd97) + {3'b000, idx};
      end else begin
         case (scan)
            8'h45: res = 8'd48;  8'h16: res = 8'd49;  8'h1E: res = 8'd50;
            8'h26: res = 8'd51;  8'h25: res = 8'd52;  8'h2E: res = 8'd53;
            8'h36: res = 8'd54;  8'h3D: res = 8'd55;  8'h3E: res = 8'd56;
            8'h46: res = 8'd57;
            8'h29: res = 8'd32;  8'h5A: res = 8'd13;  8'h66: res = 8'd8;
            8'h0D: res = 8'd9;   8'h76: res = 8'd27;
            default: res = 8'd0;
         endcase
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- parser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_emit_ext  = 1'b0;
      w_emit_rel  = 1'b0;
      if (code_valid) begin
         case (r_state)
            S_IDLE: begin
               if (code_data == 8'hE0) begin
                  w_state_nxt = S_EXT;
               end else if (code_data == 8'hF0) begin
                  w_state_nxt = S_BRK;
               end else if (code_data != 8'hAA && code_data != 8'hFA &&
                            code_data != 8'hFE && code_data != 8'hEE) begin
                  w_emit = 1'b1;
               end
            end
            S_EXT: begin
               if (code_data == 8'hF0) begin
                  w_state_nxt = S_EXT_BRK;
               end else if (code_data != 8'hE0) begin
                  w_emit      = 1'b1;
                  w_emit_ext  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_BRK: begin
               if (code_data == 8'hE0) begin
                  w_state_nxt = S_EXT_BRK;
               end else if (code_data != 8'hF0) begin
                  w_emit      = 1'b1;
                  w_emit_rel  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_EXT_BRK: begin
               if (code_data != 8'hE0 && code_data != 8'hF0) begin
                  w_emit      = 1'b1;
                  w_emit_ext  = 1'b1;
                  w_emit_rel  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_make  = w_emit && !w_emit_rel;
   assign w_ascii = w_emit_ext ? 8'd0 : f_ascii(code_data, (r_shift_l | r_shift_r) ^ r_caps_on);

   // ------------------------------------------------------------- modifiers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift_l   <= 1'b0;
         r_shift_r   <= 1'b0;
         r_caps_on   <= 1'b0;
         r_caps_held <= 1'b0;
      end else if (w_emit && !w_emit_ext) begin
         if (code_data == 8'h12) begin
            r_shift_l <= !w_emit_rel;
         end
         if (code_data == 8'h59) begin
            r_shift_r <= !w_emit_rel;
         end
         if (code_data == 8'h58) begin
            if (w_emit_rel) begin
               r_caps_held <= 1'b0;
            end else begin
               if (!r_caps_held) begin
                  r_caps_on <= !r_caps_on;
               end
               r_caps_held <= 1'b1;
            end
         end
      end
   end

   // --------------------------------------------------- typematic filtering
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
   logic       r_held_valid;
   logic [7:0] r_held_scan;
   logic       r_held_ext;
   logic       w_held_match;

   assign w_held_match = r_held_valid && (r_held_scan == code_data) && (r_held_ext == w_emit_ext);
   assign w_suppress   = w_make && w_held_match;

   // Held-key state follows the keyboard even when the FIFO drops the event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_held_valid <= 1'b0;
         r_held_scan  <= 8'd0;
         r_held_ext   <= 1'b0;
      end else if (w_emit) begin
         if (!w_emit_rel) begin
            r_held_valid <= 1'b1;
            r_held_scan  <= code_data;
            r_held_ext   <= w_emit_ext;
         end else if (w_held_match) begin
            r_held_valid <= 1'b0;
         end
      end
   end
`else
   assign w_suppress = 1'b0;
`endif

   // ------------------------------------------------------------ event FIFO
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_pop      = !w_empty && ev_ready;
   assign w_push_req = w_emit && !w_suppress;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= {w_ascii, code_data, w_emit_rel, w_emit_ext};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_key_cnt  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_emit_rel) begin
            r_key_cnt <= r_key_cnt + 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign w_head     = r_mem[r_rd_ptr[c_AW-1:0]];
   assign ev_valid   = !w_empty;
   assign ev_ascii   = ev_valid ? w_head[17:10] : 8'd0;
   assign ev_scan    = ev_valid ? w_head[9:2]   : 8'd0;
   assign ev_release = ev_valid && w_head[1];
   assign ev_ext     = ev_valid && w_head[0];
   assign shift_held = r_shift_l | r_shift_r;
   assign caps_on    = r_caps_on;
   assign key_cnt    = r_key_cnt;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Purpose  : directed self-checking bench for ps2_key_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       code_valid = 1'b0;
   logic [7:0] code_data = 8'd0;
   logic       ev_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       ev_valid;
   logic [7:0] ev_ascii;
   logic [7:0] ev_scan;
   logic       ev_release;
   logic       ev_ext;
   logic       shift_held;
   logic       caps_on;
   logic [7:0] key_cnt;
   logic       overflow;

   int n_assert = 0;
   int n_fail   = 0;

   ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_W(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .code_valid (code_valid),
      .code_data  (code_data),
      .ev_ready   (ev_ready),
      .ovf_clr    (ovf_clr),
      .ev_valid   (ev_valid),
      .ev_ascii   (ev_ascii),
      .ev_scan    (ev_scan),
      .ev_release (ev_release),
      .ev_ext     (ev_ext),
      .shift_held (shift_held),
      .caps_on    (caps_on),
      .key_cnt    (key_cnt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive on falling edge, sampled by the DUT on the rising edge.
   task automatic cycle(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
      @(negedge clk);
      code_valid = v;
      code_data  = b;
      ev_ready   = rdy;
      ovf_clr    = clr;
      @(negedge clk);
      code_valid = 1'b0;
      ev_ready   = 1'b0;
      ovf_clr    = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pop_ev(input string tag, input logic [7:0] asc, input logic [7:0] scan,
                         input logic rel, input logic ext);
      check({tag, ".valid"},   {31'd0, ev_valid},   32'd1);
      check({tag, ".ascii"},   {24'd0, ev_ascii},   {24'd0, asc});
      check({tag, ".scan"},    {24'd0, ev_scan},    {24'd0, scan});
      check({tag, ".release"}, {31'd0, ev_release}, {31'd0, rel});
      check({tag, ".ext"},     {31'd0, ev_ext},     {31'd0, ext});
      cycle(1'b0, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic drain(output int n);
      n = 0;
      while (ev_valid && n < 32) begin
         cycle(1'b0, 8'd0, 1'b1, 1'b0);
         n++;
      end
   endtask

   function automatic logic [7:0] ovf_byte(input int i);
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
      return (i % 2 == 1) ? 8'h1E : 8'h16;
`else
      return 8'h16;
`endif
   endfunction

   initial begin
      int n;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst.ev_valid", {31'd0, ev_valid}, 32'd0);
      check("rst.ev_ascii", {24'd0, ev_ascii}, 32'd0);
      check("rst.key_cnt",  {24'd0, key_cnt},  32'd0);
      check("rst.overflow", {31'd0, overflow}, 32'd0);
      check("rst.shift",    {31'd0, shift_held}, 32'd0);
      check("rst.caps",     {31'd0, caps_on},  32'd0);
      rst = 1'b0;

      // Plain make then break of 'a'
      send(8'h1C);
      check("t1.latency", {31'd0, ev_valid}, 32'd1);
      send(8'hF0);
      send(8'h1C);
      pop_ev("t1.make", 8'd97, 8'h1C, 1'b0, 1'b0);
      pop_ev("t1.brk",  8'd97, 8'h1C, 1'b1, 1'b0);
      check("t1.empty",   {31'd0, ev_valid}, 32'd0);
      check("t1.key_cnt", {24'd0, key_cnt},  32'd1);

      // Shift changes letter case
      do_reset();
      send(8'h12);
      check("t2.shift_on", {31'd0, shift_held}, 32'd1);
      send(8'h1C);
      send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12);
      check("t2.shift_off", {31'd0, shift_held}, 32'd0);
      send(8'h1C);
      pop_ev("t2.shm",  8'd0,  8'h12, 1'b0, 1'b0);
      pop_ev("t2.A",    8'd65, 8'h1C, 1'b0, 1'b0);
      pop_ev("t2.Abrk", 8'd65, 8'h1C, 1'b1, 1'b0);
      pop_ev("t2.shb",  8'd0,  8'h12, 1'b1, 1'b0);
      pop_ev("t2.a",    8'd97, 8'h1C, 1'b0, 1'b0);
      check("t2.key_cnt", {24'd0, key_cnt}, 32'd3);

      // Caps Lock, then Shift inverts it
      do_reset();
      send(8'h58); send(8'hF0); send(8'h58);
      check("t3.caps", {31'd0, caps_on}, 32'd1);
      send(8'h2B);
      send(8'h12); send(8'h2B);
      pop_ev("t3.capm", 8'd0,   8'h58, 1'b0, 1'b0);
      pop_ev("t3.capb", 8'd0,   8'h58, 1'b1, 1'b0);
      pop_ev("t3.F",    8'd70,  8'h2B, 1'b0, 1'b0);
      pop_ev("t3.shm",  8'd0,   8'h12, 1'b0, 1'b0);
      pop_ev("t3.f",    8'd102, 8'h2B, 1'b0, 1'b0);
      check("t3.key_cnt", {24'd0, key_cnt}, 32'd4);

      // Extended make/break
      do_reset();
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      pop_ev("t4.make", 8'd0, 8'h75, 1'b0, 1'b1);
      pop_ev("t4.brk",  8'd0, 8'h75, 1'b1, 1'b1);
      check("t4.empty", {31'd0, ev_valid}, 32'd0);

      // Ignored bytes in IDLE
      send(8'hAA); send(8'hFA);
      check("t4b.ignored", {31'd0, ev_valid}, 32'd0);

      // Overflow behaviour
      do_reset();
      for (int i = 0; i < 9; i++) send(ovf_byte(i));
      check("t5.ovf",     {31'd0, overflow}, 32'd1);
      check("t5.key_cnt", {24'd0, key_cnt},  32'd8);
      check("t5.head",    {24'd0, ev_ascii}, 32'd49);
      cycle(1'b1, ovf_byte(9), 1'b0, 1'b1);
      check("t5.ovf_clr_race", {31'd0, overflow}, 32'd1);
      cycle(1'b0, 8'd0, 1'b0, 1'b1);
      check("t5.ovf_clr", {31'd0, overflow}, 32'd0);
      cycle(1'b1, ovf_byte(10), 1'b1, 1'b0);
      check("t5.pushpop_ovf", {31'd0, overflow}, 32'd0);
      check("t5.pushpop_cnt", {24'd0, key_cnt},  32'd9);
      cycle(1'b0, 8'd0, 1'b1, 1'b0);
      check("t5.after_pop", {31'd0, ev_valid}, 32'd1);
      drain(n);
      check("t5.remaining", n, 32'd7);

      // Typematic repeats
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
      check("t6.key_cnt", {24'd0, key_cnt}, 32'd1);
      drain(n);
      check("t6.events", n, 32'd2);
`else
      check("t6.key_cnt", {24'd0, key_cnt}, 32'd3);
      drain(n);
      check("t6.events", n, 32'd4);
`endif

      // Reset mid-sequence returns parser to IDLE
      send(8'hF0);
      do_reset();
      check("t7.rst_empty", {31'd0, ev_valid}, 32'd0);
      send(8'h1C);
      pop_ev("t7.make", 8'd97, 8'h1C, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sequential successor to the combinational scancode-to-ASCII lookup.
- Consumes PS/2 set-2 bytes from the PS/2 receiver and parses the E0 (extended) and F0 (break) prefixes.
- Tracks Shift and Caps Lock state and produces case-correct ASCII.
- Buffers complete key events in a FIFO with a valid/ready pop handshake, read by the keyboard/display logic.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- CNT_W, 8, width of the key-press counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- code_valid  in  1  one-cycle strobe; code_data is valid.
- code_data  in  8  received scancode byte.
- ev_ready  in  1  consumer accepts the head event.
- ovf_clr  in  1  clears the overflow flag.
- ev_valid  out  1  FIFO not empty.
- ev_ascii  out  8  head-event ASCII code; 0 if unmapped.
- ev_scan  out  8  head-event scancode, with prefixes stripped.
- ev_release  out  1  head event is a break.
- ev_ext  out  1  head event carried the E0 prefix.
- shift_held  out  1  left Shift (0x12) or right Shift (0x59) currently down.
- caps_on  out  1  Caps Lock latch.
- key_cnt  out  CNT_W  count of accepted make events.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - Parser returns to IDLE; FIFO is emptied.
  - All outputs go to 0; held/Shift/Caps state is cleared.
- Parser FSM advances only on code_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; AA/FA/FE/EE are ignored; any other byte emits a make event and stays in IDLE.
  - EXT: F0 -> EXT_BRK; E0 stays in EXT; other bytes emit an ext make event -> IDLE.
  - BRK: E0 -> EXT_BRK; F0 stays in BRK; other bytes emit a break event -> IDLE.
  - EXT_BRK: E0/F0 stay in EXT_BRK; other bytes emit an ext break event -> IDLE.
- ASCII map (non-ext events only; ext events give ascii 0):
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to A..Z. Uppercase (65..90) when shift_held XOR caps_on, otherwise lowercase (97..122).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'; Shift has no effect.
  - 29->32, 5A->13, 66->8, 0D->9, 76->27.
  - Everything else -> 0.
  - ASCII is computed from Shift/Caps state before the current byte updates that state.
- Modifiers:
  - Shift make/break sets/clears its own L/R bit.
  - Caps (58) make toggles caps_on only when Caps is not already held. Caps break clears the held flag.
  - Modifier events are still pushed into the FIFO.
- FIFO push and count:
  - The final byte's event is written on the same edge; ev_valid is high the next cycle, so latency is 1 clk from the final code_valid.
  - key_cnt increments, wrapping, on every make event that is pushed.
  - Push while full: the event is dropped, overflow is set, and key_cnt does not increment.
- FIFO pop:
  - Pop occurs when ev_valid && ev_ready. Outputs reflect the head entry (first-word fall-through).
  - Simultaneous push and pop when full: both happen and there is no overflow.
  - Pop when empty: no effect.
- Overflow flag: ovf_clr clears it. If ovf_clr and an overflow occur in the same cycle, the flag stays set.

Optional Feature:
- Macro: PS2_TYPEMATIC_SUPPRESS_EN.
- When defined:
  - A held-key register (scan + ext + valid) tracks the last make.
  - Repeat makes of the held key push no event and do not increment key_cnt.
  - A matching break clears the register; a different make replaces it.
- When undefined: every make is pushed, including typematic repeats.

Test Plan:
- 1C, then F0 1C -> two events: {ascii 97, scan 1C, release 0}, then {97, 1C, release 1}; key_cnt = 1.
- 12, 1C, F0 12, 1C -> 1C events with ascii 65 then 97; shift_held is 1, then 0.
- 58, F0 58, 2B -> caps_on = 1; 2B gives ascii 70. Then 12, 2B -> ascii 102.
- E0 75, E0 F0 75 -> {ascii 0, scan 75, ext 1, release 0}, then {0, 75, 1, 1}.
- 9 makes 16 with ev_ready = 0 and DEPTH 8 (macro off) -> 8 entries of ascii 49; overflow = 1; key_cnt = 8. Pop 1 -> ev_valid stays 1. ovf_clr -> overflow = 0.
- 1C 1C 1C F0 1C with macro on -> 2 events, key_cnt = 1. With macro off -> 4 events. Separately: F0, assert rst, release rst, then 1C -> make event with release 0.
